// File: rtl/riscv_state_dump.sv
// Architectural state dumper: streams x0..x31 and then the data memory (packed
// little-endian words) over a valid/ready link while keeping a running checksum.
`timescale 1ns/1ps
module riscv_state_dump #(
    parameter int NB_DATA     = 32,
    parameter int N_REGS      = 32,
    parameter int NB_RF_ADDR  = 5,
    parameter int MEM_SIZE    = 256,
    parameter int NB_MEM_ADDR = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [NB_RF_ADDR-1:0]  o_rf_addr,
    input  logic [NB_DATA-1:0]     i_rf_data,
    output logic                   o_mem_rd,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [7:0]             i_mem_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [NB_DATA-1:0]     o_data,
    output logic                   o_tag,
    output logic [7:0]             o_index,
    output logic                   o_last,
    output logic [NB_DATA-1:0]     o_checksum
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RF_REQ   = 3'd1,
        ST_RF_WAIT  = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_OUT      = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [NB_RF_ADDR-1:0]  LAST_REG  = NB_RF_ADDR'(N_REGS - 1);
    localparam logic [NB_RF_ADDR-1:0]  ONE_REG   = NB_RF_ADDR'(1);
    localparam logic [NB_MEM_ADDR-1:0] LAST_BYTE = NB_MEM_ADDR'(MEM_SIZE - 4);
    localparam logic [NB_MEM_ADDR-1:0] WORD_STEP = NB_MEM_ADDR'(4);

    state_t                   state_r;
    state_t                   state_next;
    logic [NB_RF_ADDR-1:0]    reg_idx_r;
    logic [NB_RF_ADDR-1:0]    reg_idx_next;
    logic [NB_MEM_ADDR-1:0]   byte_idx_r;
    logic [NB_MEM_ADDR-1:0]   byte_idx_next;
    logic [1:0]               req_cnt_r;
    logic [1:0]               req_cnt_next;
    logic                     start_acc_s;
    logic                     handshake_s;
    logic                     rd_pend_r;
    logic [1:0]               rd_lane_r;

    logic                     busy_r;
    logic                     done_r;
    logic [NB_RF_ADDR-1:0]    rf_addr_r;
    logic                     mem_rd_r;
    logic [NB_MEM_ADDR-1:0]   mem_addr_r;
    logic                     valid_r;
    logic [NB_DATA-1:0]       data_r;
    logic                     tag_r;
    logic [7:0]               index_r;
    logic                     last_r;
    logic [NB_DATA-1:0]       checksum_r;

    // Next-state and walk-counter logic.
    always_comb begin
        state_next    = state_r;
        reg_idx_next  = reg_idx_r;
        byte_idx_next = byte_idx_r;
        req_cnt_next  = req_cnt_r;
        start_acc_s   = 1'b0;
        handshake_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_next    = ST_RF_REQ;
                    reg_idx_next  = {NB_RF_ADDR{1'b0}};
                    byte_idx_next = {NB_MEM_ADDR{1'b0}};
                    req_cnt_next  = 2'd0;
                    start_acc_s   = 1'b1;
                end else begin
                    state_next = state_r;
                end
            end
            ST_RF_REQ:   state_next = ST_RF_WAIT;
            ST_RF_WAIT:  state_next = ST_OUT;
            ST_MEM_REQ: begin
                if (req_cnt_r == 2'd3) begin
                    state_next   = ST_MEM_WAIT;
                    req_cnt_next = 2'd0;
                end else begin
                    req_cnt_next = req_cnt_r + 2'd1;
                end
            end
            ST_MEM_WAIT: state_next = ST_OUT;
            ST_OUT: begin
                if (i_ready) begin
                    handshake_s = 1'b1;
                    if (reg_idx_r != LAST_REG) begin
                        reg_idx_next = reg_idx_r + ONE_REG;
                        state_next   = ST_RF_REQ;
                    end else if (!tag_r) begin
                        state_next = ST_MEM_REQ;
                    end else if (byte_idx_r != LAST_BYTE) begin
                        byte_idx_next = byte_idx_r + WORD_STEP;
                        state_next    = ST_MEM_REQ;
                    end else begin
                        state_next = ST_DONE;
                    end
                end else begin
                    state_next = ST_OUT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counters and control outputs, all decoded from the next state so they are registered.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            reg_idx_r  <= {NB_RF_ADDR{1'b0}};
            byte_idx_r <= {NB_MEM_ADDR{1'b0}};
            req_cnt_r  <= 2'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            valid_r    <= 1'b0;
            mem_rd_r   <= 1'b0;
            rd_pend_r  <= 1'b0;
            rd_lane_r  <= 2'd0;
            rf_addr_r  <= {NB_RF_ADDR{1'b0}};
            mem_addr_r <= {NB_MEM_ADDR{1'b0}};
            checksum_r <= {NB_DATA{1'b0}};
        end else begin
            state_r    <= state_next;
            reg_idx_r  <= reg_idx_next;
            byte_idx_r <= byte_idx_next;
            req_cnt_r  <= req_cnt_next;
            busy_r     <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done_r     <= (state_next == ST_DONE);
            valid_r    <= (state_next == ST_OUT);
            mem_rd_r   <= (state_next == ST_MEM_REQ);
            rd_pend_r  <= mem_rd_r;
            rd_lane_r  <= mem_addr_r[1:0];
            if (state_next == ST_RF_REQ) begin
                rf_addr_r <= reg_idx_next;
            end else begin
                rf_addr_r <= rf_addr_r;
            end
            if (state_next == ST_MEM_REQ) begin
                mem_addr_r <= byte_idx_next + {{(NB_MEM_ADDR-2){1'b0}}, req_cnt_next};
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (start_acc_s) begin
                checksum_r <= {NB_DATA{1'b0}};
            end else if (handshake_s) begin
                checksum_r <= checksum_r + data_r;
            end else begin
                checksum_r <= checksum_r;
            end
        end
    end

    // Beat payload: register capture, byte-lane assembly of memory words, tag/index/last.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_r  <= {NB_DATA{1'b0}};
            tag_r   <= 1'b0;
            index_r <= 8'd0;
            last_r  <= 1'b0;
        end else if (state_r == ST_RF_WAIT) begin
            data_r  <= i_rf_data;
            tag_r   <= 1'b0;
            index_r <= {{(8-NB_RF_ADDR){1'b0}}, reg_idx_r};
            last_r  <= 1'b0;
        end else begin
            if (rd_pend_r) begin
                case (rd_lane_r)
                    2'd0:    data_r[7:0]   <= i_mem_data;
                    2'd1:    data_r[15:8]  <= i_mem_data;
                    2'd2:    data_r[23:16] <= i_mem_data;
                    2'd3:    data_r[31:24] <= i_mem_data;
                    default: data_r        <= data_r;
                endcase
            end else begin
                data_r <= data_r;
            end
            if (state_r == ST_MEM_WAIT) begin
                tag_r   <= 1'b1;
                index_r <= {{(10-NB_MEM_ADDR){1'b0}}, byte_idx_r[NB_MEM_ADDR-1:2]};
                last_r  <= (byte_idx_r == LAST_BYTE);
            end else begin
                tag_r   <= tag_r;
                index_r <= index_r;
                last_r  <= last_r;
            end
        end
    end

    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_rf_addr  = rf_addr_r;
    assign o_mem_rd   = mem_rd_r;
    assign o_mem_addr = mem_addr_r;
    assign o_valid    = valid_r;
    assign o_data     = data_r;
    assign o_tag      = tag_r;
    assign o_index    = index_r;
    assign o_last     = last_r;
    assign o_checksum = checksum_r;

endmodule

// File: tb/tb_riscv_state_dump.sv
// Self-checking bench for riscv_state_dump: register file and memory models,
// randomized backpressure and contents, compared against an expected beat list.
`timescale 1ns/1ps
module tb_riscv_state_dump;

    typedef struct packed {
        logic        tag;
        logic [7:0]  index;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        i_clock;
    logic        i_reset_n;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [4:0]  o_rf_addr;
    logic [31:0] i_rf_data;
    logic        o_mem_rd;
    logic [7:0]  o_mem_addr;
    logic [7:0]  i_mem_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_tag;
    logic [7:0]  o_index;
    logic        o_last;
    logic [31:0] o_checksum;

    riscv_state_dump dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done),
        .o_rf_addr(o_rf_addr), .i_rf_data(i_rf_data),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag),
        .o_index(o_index), .o_last(o_last), .o_checksum(o_checksum)
    );

    logic [31:0] rf  [32];
    logic [7:0]  mem [256];

    beat_t       got_q[$];
    beat_t       exp_q[$];
    logic [31:0] exp_sum;
    int          n_vec;
    int          n_err;
    int          first_valid;
    int          done_cycle;
    int          stall_viol;
    int          rd_viol;
    logic        busy_at1;
    logic        done_at1;
    logic [31:0] cks_at1;

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Register file and byte memory with one-cycle read latency.
    always @(posedge i_clock) begin
        i_rf_data <= rf[o_rf_addr];
        if (o_mem_rd) i_mem_data <= mem[o_mem_addr];
    end

    task automatic fill_default();
        for (int k = 0; k < 32; k++) rf[k] = 32'(k) * 32'h01010101;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    endtask

    // Reference: every register in order, then memory words packed little-endian.
    task automatic build_expected();
        beat_t b;
        exp_q.delete();
        exp_sum = 32'd0;
        for (int k = 0; k < 32; k++) begin
            b = {1'b0, 8'(k), rf[k], 1'b0};
            exp_q.push_back(b);
        end
        for (int w = 0; w < 64; w++) begin
            b = {1'b1, 8'(w), mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w], (w == 63)};
            exp_q.push_back(b);
        end
        foreach (exp_q[i]) exp_sum = exp_sum + exp_q[i].data;
    endtask

    // Pulses start, then runs cycle by cycle collecting accepted beats until o_done.
    task automatic run_dump(input int low_pct, input int mid_start);
        beat_t cur;
        beat_t pb;
        logic  pv;
        int    cyc;
        got_q.delete();
        first_valid = -1;
        done_cycle  = -1;
        stall_viol  = 0;
        rd_viol     = 0;
        pv          = 1'b0;
        pb          = '0;
        i_ready     = 1'b1;
        i_start     = 1'b1;
        @(posedge i_clock);
        cyc = 1;
        @(negedge i_clock);
        i_start  = 1'b0;
        busy_at1 = o_busy;
        done_at1 = o_done;
        cks_at1  = o_checksum;
        while (cyc < 20000) begin
            if (o_done) begin
                done_cycle = cyc;
                break;
            end
            i_ready = ($urandom_range(0, 99) >= low_pct);
            cur = {o_tag, o_index, o_data, o_last};
            if (o_valid && first_valid < 0) first_valid = cyc;
            if (o_valid && o_mem_rd) rd_viol++;
            if (pv && (!o_valid || cur != pb)) stall_viol++;
            if (o_valid && i_ready) got_q.push_back(cur);
            pv = o_valid && !i_ready;
            pb = cur;
            i_start = (cyc == mid_start);
            @(posedge i_clock);
            cyc++;
            @(negedge i_clock);
        end
        i_start = 1'b0;
        i_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [90:0] outs;
        outs = {o_busy, o_done, o_rf_addr, o_mem_rd, o_mem_addr, o_valid,
                o_data, o_tag, o_index, o_last, o_checksum};
        n_vec++;
        if (outs !== 91'd0) begin
            n_err++;
            $display("FAIL reset_in: outputs %h, expected all zero", outs);
        end
        i_reset_n = 1'b1;
        repeat (5) @(negedge i_clock);
        outs = {o_busy, o_done, o_rf_addr, o_mem_rd, o_mem_addr, o_valid,
                o_data, o_tag, o_index, o_last, o_checksum};
        n_vec++;
        if (outs !== 91'd0) begin
            n_err++;
            $display("FAIL reset_idle: outputs %h, expected all zero", outs);
        end
    endtask

    task automatic test_basic_dump();
        beat_t b;
        fill_default();
        build_expected();
        run_dump(0, -1);
        n_vec++;
        if (got_q.size() != 96) begin
            n_err++;
            $display("FAIL basic_count: got %0d beats, expected 96", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL basic_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        b = (got_q.size() > 5) ? got_q[5] : '0;
        n_vec++;
        if (b !== {1'b0, 8'd5, 32'h05050505, 1'b0}) begin
            n_err++;
            $display("FAIL beat5: got %h expected tag0 idx5 05050505", b);
        end
        b = (got_q.size() > 32) ? got_q[32] : '0;
        n_vec++;
        if (b !== {1'b1, 8'd0, 32'h03020100, 1'b0}) begin
            n_err++;
            $display("FAIL beat32: got %h expected tag1 idx0 03020100", b);
        end
        b = (got_q.size() > 95) ? got_q[95] : '0;
        n_vec++;
        if (b !== {1'b1, 8'd63, 32'hFFFEFDFC, 1'b1}) begin
            n_err++;
            $display("FAIL final_beat: got %h expected tag1 idx63 FFFEFDFC last", b);
        end
        n_vec++;
        if (first_valid != 3) begin
            n_err++;
            $display("FAIL first_valid: got cycle %0d expected 3", first_valid);
        end
        n_vec++;
        if (done_cycle != 481) begin
            n_err++;
            $display("FAIL done_latency: got cycle %0d expected 481", done_cycle);
        end
        n_vec++;
        if (busy_at1 !== 1'b1) begin
            n_err++;
            $display("FAIL busy_rise: got %b expected 1", busy_at1);
        end
    endtask

    task automatic test_checksum();
        fill_default();
        build_expected();
        run_dump(0, -1);
        n_vec++;
        if (o_checksum !== exp_sum) begin
            n_err++;
            $display("FAIL cks_default: got %h expected %h", o_checksum, exp_sum);
        end
        repeat (3) @(negedge i_clock);
        n_vec++;
        if (o_checksum !== exp_sum || o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_hold: cks %h done %b busy %b expected %h 1 0",
                     o_checksum, o_done, o_busy, exp_sum);
        end
        for (int k = 0; k < 32; k++) rf[k] = 32'hFFFFFFFF;
        for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
        build_expected();
        run_dump(0, -1);
        n_vec++;
        if (o_checksum !== 32'hFFFFFFA0 || o_checksum !== exp_sum) begin
            n_err++;
            $display("FAIL cks_all_ones: got %h expected FFFFFFA0 (model %h)", o_checksum, exp_sum);
        end
    endtask

    task automatic test_backpressure();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                fill_default();
            end else begin
                for (int k = 0; k < 32; k++) rf[k] = $urandom;
                for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            end
            build_expected();
            run_dump(30, -1);
            n_vec++;
            if (got_q.size() != exp_q.size() || done_cycle < 0) begin
                n_err++;
                $display("FAIL bp%0d_count: got %0d beats done %0d, expected 96", pass, got_q.size(), done_cycle);
            end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL bp%0d_beat%0d: got %h expected %h", pass, i, got_q[i], exp_q[i]);
                end
            end
            n_vec++;
            if (o_checksum !== exp_sum) begin
                n_err++;
                $display("FAIL bp%0d_cks: got %h expected %h", pass, o_checksum, exp_sum);
            end
            n_vec++;
            if (stall_viol != 0 || rd_viol != 0) begin
                n_err++;
                $display("FAIL bp%0d_stall: unstable %0d reads-while-stalled %0d, expected 0 0",
                         pass, stall_viol, rd_viol);
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_default();
        build_expected();
        for (int pass = 0; pass < 2; pass++) begin
            run_dump(0, (pass == 0) ? int'($urandom_range(10, 400)) : -1);
            n_vec++;
            if (got_q.size() != 96 || done_cycle != 481) begin
                n_err++;
                $display("FAIL b2b%0d_count: got %0d beats done %0d, expected 96 481", pass, got_q.size(), done_cycle);
            end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL b2b%0d_beat%0d: got %h expected %h", pass, i, got_q[i], exp_q[i]);
                end
            end
            n_vec++;
            if (o_checksum !== exp_sum) begin
                n_err++;
                $display("FAIL b2b%0d_cks: got %h expected %h", pass, o_checksum, exp_sum);
            end
        end
        n_vec++;
        if (done_at1 !== 1'b0 || busy_at1 !== 1'b1 || cks_at1 !== 32'd0) begin
            n_err++;
            $display("FAIL restart_clear: done %b busy %b cks %h expected 0 1 0", done_at1, busy_at1, cks_at1);
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [90:0] outs;
        int          k;
        int          viol;
        i_ready = 1'b1;
        i_start = 1'b1;
        @(posedge i_clock);
        @(negedge i_clock);
        i_start = 1'b0;
        k = 0;
        while (!(o_mem_rd === 1'b1 && o_mem_addr === 8'd8) && k < 1000) begin
            @(posedge i_clock);
            @(negedge i_clock);
            k++;
        end
        n_vec++;
        if (k >= 1000) begin
            n_err++;
            $display("FAIL reach_mem8: waited %0d cycles, expected MEM_REQ at byte 8", k);
        end
        #2 i_reset_n = 1'b0;
        #1;
        outs = {o_busy, o_done, o_rf_addr, o_mem_rd, o_mem_addr, o_valid,
                o_data, o_tag, o_index, o_last, o_checksum};
        n_vec++;
        if (outs !== 91'd0) begin
            n_err++;
            $display("FAIL reset_async: outputs %h, expected all zero", outs);
        end
        repeat (3) @(negedge i_clock);
        i_reset_n = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge i_clock);
            if (o_busy || o_mem_rd || o_valid || o_done || o_rf_addr != 5'd0) viol++;
        end
        n_vec++;
        if (viol != 0) begin
            n_err++;
            $display("FAIL reset_stay_idle: %0d active cycles, expected 0", viol);
        end
        fill_default();
        build_expected();
        run_dump(0, -1);
        n_vec++;
        if (got_q.size() != 96 || o_checksum !== exp_sum) begin
            n_err++;
            $display("FAIL reset_recover: beats %0d cks %h expected 96 %h", got_q.size(), o_checksum, exp_sum);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        i_reset_n = 1'b0;
        i_start   = 1'b0;
        i_ready   = 1'b1;
        fill_default();
        repeat (3) @(negedge i_clock);
        test_reset();
        test_basic_dump();
        test_checksum();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_state_dump.md
Name: riscv_state_dump

Overview:
- Hardware counterpart to the bench-side result check: after a program run, it reads out architectural state and streams it to a host or checker.
- On a start pulse it walks all general registers (x0..x31), then all data-memory bytes.
- It emits one 32-bit beat per register and one packed little-endian word per 4 memory bytes, over a valid/ready stream.
- It also produces a running checksum of every accepted beat. It sits beside riscv_top, using the register-file and data-memory read ports while the core is stalled or halted.

Parameters:
NB_DATA, 32, beat / register width
N_REGS, 32, registers dumped
NB_RF_ADDR, 5, register-file address width
MEM_SIZE, 256, data-memory bytes dumped; must be a multiple of 4
NB_MEM_ADDR, 8, data-memory byte address width (log2 MEM_SIZE)

Ports:
i_clock  in  1  clock
i_reset_n  in  1  reset, asynchronous, active-low
i_start  in  1  begin dump; sampled only in IDLE or DONE
o_busy  out  1  dump in progress
o_done  out  1  dump finished; held until next accepted start
o_rf_addr  out  NB_RF_ADDR  register-file read address
i_rf_data  in  NB_DATA  register data, valid one cycle after o_rf_addr
o_mem_rd  out  1  data-memory read strobe
o_mem_addr  out  NB_MEM_ADDR  data-memory byte address
i_mem_data  in  8  memory byte, valid one cycle after o_mem_rd
o_valid  out  1  beat valid
i_ready  in  1  sink accepts beat
o_data  out  NB_DATA  beat payload
o_tag  out  1  0 = register beat, 1 = memory beat
o_index  out  8  register number, or memory word index (byte address/4)
o_last  out  1  final beat of dump
o_checksum  out  NB_DATA  sum mod 2^32 of all accepted beats

Behaviour:
- Reset (async assert, sync deassert expected): state IDLE; all outputs and internal counters 0. This includes o_checksum and o_done.
- Reset mid-dump aborts immediately with no further memory or RF reads.
- FSM states: IDLE, RF_REQ, RF_WAIT, MEM_REQ, MEM_WAIT, OUT, DONE.
- IDLE/DONE + i_start=1:
  - clear checksum, reg_idx and byte_idx;
  - go to RF_REQ;
  - o_done drops and o_busy rises on the same edge.
- i_start is ignored while o_busy=1.
- RF_REQ: o_rf_addr=reg_idx; go to RF_WAIT.
- RF_WAIT: capture i_rf_data into the output register; set o_tag=0 and o_index=reg_idx; go to OUT.
- x0 is dumped as read; there is no forcing to 0.
- MEM_REQ:
  - o_mem_rd=1 and o_mem_addr=byte_idx for 4 consecutive cycles (byte_idx, +1, +2, +3);
  - byte returned in the following cycle lands in lane (addr mod 4), so byte k goes to o_data[8k+7:8k];
  - after the 4th request go to MEM_WAIT.
- MEM_WAIT: capture the last byte; set o_tag=1 and o_index=byte_idx/4; go to OUT.
- o_mem_rd=0 in all other states.
- OUT:
  - o_valid=1; o_data, o_tag, o_index and o_last are held stable until i_ready=1.
  - On the handshake: o_checksum += o_data (wraps mod 2^32).
  - After handshake, next state:
    - reg_idx<N_REGS-1: reg_idx++, RF_REQ;
    - reg_idx==N_REGS-1 and no memory beat sent yet: MEM_REQ;
    - memory beat and byte_idx+4<MEM_SIZE: byte_idx+=4, MEM_REQ;
    - otherwise DONE.
- o_last=1 only on the final memory beat (index MEM_SIZE/4-1).
- DONE: o_busy=0, o_done=1, o_checksum stable.
- Latency with i_ready tied 1:
  - first o_valid in the 3rd cycle after i_start is sampled;
  - register beat = 3 cycles; memory beat = 6 cycles;
  - total = 3*N_REGS + 6*MEM_SIZE/4 = 480 cycles with defaults; o_done=1 on the following cycle.
- Backpressure: i_ready low stalls in OUT indefinitely; no reads are issued while stalled.
- Counters never wrap: byte_idx stops at MEM_SIZE-4 and reg_idx at N_REGS-1.

Test Plan:
- Reset, then i_start. RF has Rk=k*0x01010101, memory byte a = a[7:0], i_ready=1. Required response:
  - 96 beats;
  - beat 5 has o_tag=0, o_index=5, o_data=0x05050505;
  - beat 32 has o_tag=1, o_index=0, o_data=0x03020100;
  - final beat has o_index=63, o_data=0xFFFEFDFC, o_last=1;
  - o_done rises 481 cycles after start.
- Same memory contents as the first test, checksum check: o_checksum = sum of all 96 beats mod 2^32, compared against the bench model. Also rerun with all memory 0xFF and all regs 0xFFFFFFFF; required result o_checksum = 96*0xFFFFFFFF mod 2^32 = 0xFFFFFFA0.
- Random i_ready toggling (about 30% low): identical beat sequence and checksum to the first test; payload is stable while o_valid=1 and i_ready=0; no o_mem_rd while stalled in OUT.
- i_start pulsed again mid-dump: ignored, with sequence and count unchanged. After DONE, a second start clears o_done and the checksum and repeats an identical dump.
- Assert i_reset_n low while in MEM_REQ (byte_idx=8):
  - all outputs go to 0 immediately, without waiting for a clock edge;
  - after release the block stays in IDLE until i_start.
